// File: rtl/eth_rx_frame_filter_if.sv
// eth_rx_frame_filter_if: byte-wide AXI-Stream link without backpressure
interface eth_rx_frame_filter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  modport master(output tdata, tvalid, tlast, tuser);
  modport slave(input tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: rx destination-address filter with 6-byte holding delay, FCS/length check and statistics
module eth_rx_frame_filter #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                         clk_int,
  input  logic                         rst_int,
  input  logic [47:0]                  mac_address,
  input  logic                         promiscuous,
  eth_rx_frame_filter_if.slave         s_axis,
  eth_rx_frame_filter_if.master        m_axis,
  output logic                         frame_done,
  output logic [10:0]                  last_len,
  output logic [15:0]                  stat_ok,
  output logic [15:0]                  stat_dropped,
  output logic [15:0]                  stat_bad,
  output logic                         overrun
);
  typedef enum logic [2:0] {IDLE, HDR, PASS, DROP, FLUSH} state_t;
  state_t      state;
  logic [47:0] hold;
  logic [10:0] len;
  logic [10:0] len_inc;
  logic [31:0] crc;
  logic [2:0]  fcnt;
  logic        tuser_l;
  logic        ovr_pend;
  logic [47:0] dst;
  logic        accept;
  logic        bad;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign len_inc = (&len) ? len : len + 11'd1;
  assign dst     = {hold[39:0], s_axis.tdata};
  assign accept  = promiscuous | (&dst) | (dst[47:24] == 24'h01005E) | (dst == mac_address);
  assign bad     = tuser_l | (crc != 32'hDEBB20E3) | (len < 11'(MIN_LEN)) | (len > 11'(MAX_LEN));
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state         <= IDLE;
      hold          <= '0;
      len           <= '0;
      crc           <= '1;
      fcnt          <= '0;
      tuser_l       <= 1'b0;
      ovr_pend      <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      frame_done    <= 1'b0;
      last_len      <= '0;
      stat_ok       <= '0;
      stat_dropped  <= '0;
      stat_bad      <= '0;
      overrun       <= 1'b0;
    end else begin
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        IDLE: if (s_axis.tvalid) begin
          hold <= dst;
          len  <= 11'd1;
          crc  <= crc_upd('1, s_axis.tdata);
          if (s_axis.tlast) begin
            frame_done   <= 1'b1;
            last_len     <= 11'd1;
            stat_dropped <= stat_dropped + 16'd1;
          end else state <= HDR;
        end
        HDR: if (s_axis.tvalid) begin
          hold <= dst;
          len  <= len_inc;
          crc  <= crc_upd(crc, s_axis.tdata);
          if (s_axis.tlast && len_inc < 11'd6) begin
            frame_done   <= 1'b1;
            last_len     <= len_inc;
            stat_dropped <= stat_dropped + 16'd1;
            state        <= IDLE;
          end else if (len_inc == 11'd6) begin
            if (!s_axis.tlast) state <= accept ? PASS : DROP;
            else if (accept) begin
              tuser_l <= s_axis.tuser;
              fcnt    <= '0;
              state   <= FLUSH;
            end else begin
              frame_done   <= 1'b1;
              last_len     <= len_inc;
              stat_dropped <= stat_dropped + 16'd1;
              state        <= IDLE;
            end
          end
        end
        PASS: if (s_axis.tvalid) begin
          hold          <= dst;
          len           <= len_inc;
          crc           <= crc_upd(crc, s_axis.tdata);
          m_axis.tdata  <= hold[47:40];
          m_axis.tvalid <= 1'b1;
          if (s_axis.tlast) begin
            tuser_l <= s_axis.tuser;
            fcnt    <= '0;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          m_axis.tdata  <= hold[47:40];
          m_axis.tvalid <= 1'b1;
          hold          <= {hold[39:0], 8'h00};
          fcnt          <= fcnt + 3'd1;
          if (s_axis.tvalid) begin
            overrun  <= 1'b1;
            ovr_pend <= 1'b1;
          end
          if (fcnt == 3'd5) begin
            m_axis.tlast <= 1'b1;
            m_axis.tuser <= bad;
            frame_done   <= 1'b1;
            last_len     <= len;
            stat_ok      <= bad ? stat_ok : stat_ok + 16'd1;
            stat_bad     <= bad ? stat_bad + 16'd1 : stat_bad;
            len          <= '0;
            ovr_pend     <= 1'b0;
            state        <= (ovr_pend | s_axis.tvalid) ? DROP : IDLE;
          end
        end
        DROP: if (s_axis.tvalid) begin
          len <= len_inc;
          if (s_axis.tlast) begin
            frame_done   <= 1'b1;
            last_len     <= len_inc;
            stat_dropped <= stat_dropped + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
